// File: rtl/bin_frame_serializer.sv
// bin_frame_serializer
//
// Captures one averaged frame from the channelizer on an in_valid pulse and
// streams it to the readout link over a valid/ready stream:
//    sync word, frame-count word, WORDS data words (word 0 first)
//    [, checksum word when SERIALIZER_CHECKSUM_EN is defined]
//
// Optional build macro: SERIALIZER_CHECKSUM_EN
//    Appends a CSUM beat (XOR of the count word and all data words of the
//    captured frame). m_last and the back-to-back capture window move to it.
//
// Ports:
//    clk       system clock
//    arest_n   asynchronous active-low reset
//    in_valid  single-cycle frame strobe
//    in_data   averaged frame, WORDS words of N_out bits
//    m_data    stream data
//    m_valid   stream valid (driven from state only)
//    m_ready   stream ready from downstream
//    m_last    final beat of a frame
//    busy      high whenever a frame is in flight
//    overflow  sticky; a frame arrived while busy and was dropped
//
// state | meaning
// IDLE  | waiting for in_valid
// SYNC  | presenting SYNC_WORD
// COUNT | presenting the frame counter
// DATA  | presenting captured word[idx]
// CSUM  | presenting the checksum (checksum build only)

module bin_frame_serializer #(
   parameter int               N         = 16,
   parameter int               N_out     = 8,
   parameter int               BINS      = 4,
   parameter logic [N_out-1:0] SYNC_WORD = 8'hA5
) (
   input  logic                          clk,
   input  logic                          arest_n,
   input  logic                          in_valid,
   input  logic [BINS*N/N_out-1:0][N_out-1:0] in_data,
   output logic [N_out-1:0]              m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          m_last,
   output logic                          busy,
   output logic                          overflow
);

   localparam int WORDS = BINS * N / N_out;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   generate
      if ((BINS * N) % N_out != 0) begin : g_bad_ratio
         $error("bin_frame_serializer: BINS*N must be a multiple of N_out");
      end
   endgenerate

`ifdef SERIALIZER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, SYNC, COUNT, DATA, CSUM} state_t;
`else
   typedef enum logic [2:0] {IDLE, SYNC, COUNT, DATA} state_t;
`endif

   state_t                      state, state_nxt;
   logic [WORDS-1:0][N_out-1:0] frame_q;
   logic [IDX_W-1:0]            idx;
   logic [N_out-1:0]            frame_cnt;
   logic                        beat, last_data;
   logic                        capture, idx_clr, idx_inc, cnt_inc;

   // Valid comes from registered state only, so it never depends on m_ready
   // and drops asynchronously with reset.
   assign m_valid   = (state != IDLE);
   assign busy      = (state != IDLE);
   assign beat      = m_valid && m_ready;
   assign last_data = (state == DATA) && (idx == IDX_W'(WORDS - 1));

`ifdef SERIALIZER_CHECKSUM_EN
   logic [N_out-1:0] csum;

   always_comb begin
      csum = frame_cnt;
      for (int i = 0; i < WORDS; i++) begin
         csum = csum ^ frame_q[i];
      end
   end
`endif

   always_ff @(posedge clk or negedge arest_n) begin
      if (!arest_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      m_data    = '0;
      m_last    = 1'b0;
      capture   = 1'b0;
      idx_clr   = 1'b0;
      idx_inc   = 1'b0;
      cnt_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               capture   = 1'b1;
               state_nxt = SYNC;
            end
         end
         SYNC: begin
            m_data = SYNC_WORD;
            if (beat) state_nxt = COUNT;
         end
         COUNT: begin
            m_data = frame_cnt;
            if (beat) begin
               state_nxt = DATA;
               idx_clr   = 1'b1;
            end
         end
         DATA: begin
            m_data = frame_q[idx];
`ifdef SERIALIZER_CHECKSUM_EN
            if (beat) begin
               if (last_data) state_nxt = CSUM;
               else           idx_inc   = 1'b1;
            end
`else
            m_last = last_data;
            if (beat) begin
               if (last_data) begin
                  cnt_inc = 1'b1;
                  // A frame arriving on the final beat is taken without a bubble.
                  if (in_valid) begin
                     capture   = 1'b1;
                     state_nxt = SYNC;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  idx_inc = 1'b1;
               end
            end
`endif
         end
`ifdef SERIALIZER_CHECKSUM_EN
         CSUM: begin
            m_data = csum;
            m_last = 1'b1;
            if (beat) begin
               cnt_inc = 1'b1;
               if (in_valid) begin
                  capture   = 1'b1;
                  state_nxt = SYNC;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arest_n) begin
      if (!arest_n) begin
         frame_q   <= '0;
         idx       <= '0;
         frame_cnt <= '0;
         overflow  <= 1'b0;
      end else begin
         if (capture) frame_q <= in_data;
         if (idx_clr)      idx <= '0;
         else if (idx_inc) idx <= idx + IDX_W'(1);
         if (cnt_inc) frame_cnt <= frame_cnt + N_out'(1);
         // Any strobe not taken as a capture is a dropped frame.
         if (in_valid && !capture) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bin_frame_serializer.sv
module tb_bin_frame_serializer;

   localparam int N     = 16;
   localparam int N_OUT = 8;
   localparam int BINS  = 4;
   localparam int WORDS = BINS * N / N_OUT;
   localparam logic [N_OUT-1:0] SYNC = 8'hA5;
`ifdef SERIALIZER_CHECKSUM_EN
   localparam int FLEN = WORDS + 3;
`else
   localparam int FLEN = WORDS + 2;
`endif

   typedef logic [WORDS-1:0][N_OUT-1:0] frame_t;
   typedef struct packed {
      logic [N_OUT-1:0] d;
      logic             l;
   } beat_t;

   logic             clk = 1'b0;
   logic             arest_n = 1'b0;
   logic             in_valid = 1'b0;
   frame_t           in_data = '0;
   logic [N_OUT-1:0] m_data;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic             m_last;
   logic             busy;
   logic             overflow;

   always #5 clk = ~clk;

   bin_frame_serializer #(
      .N(N), .N_out(N_OUT), .BINS(BINS), .SYNC_WORD(SYNC)
   ) dut (
      .clk(clk), .arest_n(arest_n), .in_valid(in_valid), .in_data(in_data),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .busy(busy), .overflow(overflow)
   );

   // Reference model: the expected beat stream of the frame in flight.
   beat_t            exp_q[$];
   logic [N_OUT-1:0] mdl_cnt = '0;
   logic             mdl_ovf = 1'b0;
   int               sent_frames = 0;
   int               n_chk = 0;
   int               n_fail = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void push_frame(input frame_t f);
      beat_t            b;
      logic [N_OUT-1:0] cs;
      b.d = SYNC;    b.l = 1'b0; exp_q.push_back(b);
      b.d = mdl_cnt; b.l = 1'b0; exp_q.push_back(b);
      cs = mdl_cnt;
      for (int i = 0; i < WORDS; i++) begin
         b.d = f[i];
`ifdef SERIALIZER_CHECKSUM_EN
         b.l = 1'b0;
`else
         b.l = (i == WORDS - 1);
`endif
         exp_q.push_back(b);
         cs = cs ^ f[i];
      end
`ifdef SERIALIZER_CHECKSUM_EN
      b.d = cs; b.l = 1'b1; exp_q.push_back(b);
`endif
   endfunction

   function automatic frame_t rand_frame();
      frame_t f;
      for (int i = 0; i < WORDS; i++) f[i] = N_OUT'($urandom_range(0, 255));
      return f;
   endfunction

   function automatic frame_t ramp_frame();
      frame_t f;
      for (int i = 0; i < WORDS; i++) f[i] = N_OUT'(8'h10 + i);
      return f;
   endfunction

   // One clock cycle: drive at the falling edge, compare, then advance the model.
   task automatic step(input logic iv, input logic rdy, input frame_t dat);
      logic idle, bt, lastb;
      @(negedge clk);
      in_valid = iv;
      m_ready  = rdy;
      in_data  = dat;
      #1;
      idle = (exp_q.size() == 0);
      check_val("m_valid", 32'(m_valid), 32'(!idle));
      check_val("busy", 32'(busy), 32'(!idle));
      check_val("overflow", 32'(overflow), 32'(mdl_ovf));
      if (!idle) begin
         check_val("m_data", 32'(m_data), 32'(exp_q[0].d));
         check_val("m_last", 32'(m_last), 32'(exp_q[0].l));
      end
      bt    = !idle && rdy;
      lastb = bt && exp_q[0].l;
      if (bt) void'(exp_q.pop_front());
      if (lastb) begin
         mdl_cnt = mdl_cnt + 8'd1;
         sent_frames++;
      end
      if (iv) begin
         if (idle || lastb) push_frame(dat);
         else               mdl_ovf = 1'b1;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      arest_n  = 1'b0;
      in_valid = 1'b0;
      #1;
      check_val("rst_m_valid", 32'(m_valid), 32'd0);
      check_val("rst_m_last", 32'(m_last), 32'd0);
      check_val("rst_m_data", 32'(m_data), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_overflow", 32'(overflow), 32'd0);
      exp_q.delete();
      mdl_cnt = '0;
      mdl_ovf = 1'b0;
      repeat (2) @(negedge clk);
      arest_n = 1'b1;
   endtask

   task automatic drain(input string tag);
      int guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
         step(1'b0, 1'b1, '0);
         guard++;
      end
      check_val(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      int k;
      int started;
      int base;
      logic iv;

      apply_reset();

      // Single frame at full rate
      step(1'b1, 1'b1, ramp_frame());
      repeat (FLEN + 2) step(1'b0, 1'b1, '0);
      check_val("single_done", 32'(exp_q.size()), 32'd0);

      // Backpressure pattern 1,0,0,1
      step(1'b1, 1'b1, rand_frame());
      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         step(1'b0, (k % 4 == 0) || (k % 4 == 3), '0);
         k++;
      end
      check_val("bp_done", 32'(exp_q.size()), 32'd0);

      // Drop while streaming data word 3; next frame carries count 01
      apply_reset();
      step(1'b1, 1'b1, ramp_frame());
      guard = 0;
      while (FLEN - exp_q.size() != 5 && guard < 50) begin
         step(1'b0, 1'b1, '0);
         guard++;
      end
      check_val("ovf_pos", 32'(FLEN - exp_q.size()), 32'd5);
      step(1'b1, 1'b1, rand_frame());
      drain("ovf_drain");
      step(1'b1, 1'b1, rand_frame());
      drain("ovf_next_drain");
      repeat (3) step(1'b0, 1'b0, '0);

      // Back-to-back frames through a full counter wrap (257 frames)
      apply_reset();
      base = sent_frames;
      step(1'b1, 1'b1, rand_frame());
      started = 1;
      guard = 0;
      while (exp_q.size() != 0 && guard < 300 * FLEN) begin
         iv = (exp_q.size() == 1) && (started < 257);
         if (iv) started++;
         step(iv, 1'b1, rand_frame());
         guard++;
      end
      check_val("wrap_frames", 32'(sent_frames - base), 32'd257);

      // Reset during DATA word 4, then a fresh frame
      step(1'b1, 1'b1, ramp_frame());
      guard = 0;
      while (FLEN - exp_q.size() != 6 && guard < 50) begin
         step(1'b0, 1'b1, '0);
         guard++;
      end
      check_val("rst_pos", 32'(FLEN - exp_q.size()), 32'd6);
      apply_reset();
      step(1'b1, 1'b1, ramp_frame());
      drain("post_rst_drain");

      // Randomized traffic and backpressure
      for (int c = 0; c < 3000; c++) begin
         step($urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0, rand_frame());
      end
      drain("rand_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bin_frame_serializer.md
Name: bin_frame_serializer

Overview:
- Consumer of the channelizer's averaged-bin output.
- On each valid pulse, captures the full averaged frame of BINS*N/N_out words, each N_out bits wide.
- Streams the frame out one N_out word per beat on a valid/ready stream: sync word, frame-count word, then the data words.
- Sits between the channelizer and the downstream readout link (UART/Ethernet framer).

Parameters:
- N, 16, input bin width before repacking (used only to derive WORDS)
- N_out, 8, output word width; also the width of each captured word
- BINS, 4, bins per frame
- SYNC_WORD, 8'hA5, first word of every frame; N_out bits wide
- WORDS, BINS*N/N_out (derived, localparam), data words per frame; 8 at defaults

Ports:
- clk  in  1  system clock
- arest_n  in  1  asynchronous active-low reset
- in_valid  in  1  single-cycle pulse; in_data is valid this cycle
- in_data  in  [WORDS-1:0][N_out-1:0]  averaged frame; word 0 is sent first
- m_data  out  N_out  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready from downstream
- m_last  out  1  high on the final beat of a frame
- busy  out  1  high whenever state != IDLE
- overflow  out  1  sticky; set when a frame is dropped

Behaviour:
- Clock and reset (already decided): single clock clk; reset arest_n is asynchronous, active-low.
- Reset values:
  - m_data=0, m_valid=0, m_last=0, busy=0, overflow=0
  - frame counter=0, word index=0, state=IDLE
  - Reset asserted mid-frame aborts the frame immediately; no partial-frame recovery.
- Elaboration check: BINS*N must be divisible by N_out; otherwise $error.
- Beat: a cycle with m_valid && m_ready.
- Stream rules:
  - m_data and m_last stay stable while m_valid && !m_ready.
  - m_valid never drops without a beat.
  - m_valid does not depend combinationally on m_ready.
- FSM states: IDLE, SYNC, COUNT, DATA.
  - IDLE: in_valid=1 captures in_data into a frame register and goes to SYNC. m_valid rises the next cycle (latency 1 clk from in_valid to first m_valid).
  - SYNC: m_data=SYNC_WORD. On a beat, go to COUNT.
  - COUNT: m_data = frame counter (N_out bits). On a beat, go to DATA with index=0.
  - DATA: m_data = captured word[index].
    - On a beat with index<WORDS-1: index increments.
    - On a beat with index=WORDS-1 (m_last=1): frame counter increments (wraps 2^N_out-1 -> 0).
    - After that final beat: if in_valid is high the same cycle, capture and go to SYNC (zero-bubble back-to-back); else go to IDLE with m_valid=0.
- Minimum frame length: WORDS+2 beats; every beat is one clk when m_ready=1.
- Drop rule:
  - in_valid in any state other than IDLE, except the final-beat cycle above, is ignored.
  - The captured frame is unaffected, and overflow is set to 1.
  - overflow clears only on reset.
  - The frame counter counts sent frames only, not dropped ones.
- m_ready held low indefinitely: the FSM holds its state; no timeout.
- in_valid in the same cycle reset deasserts: ignored. The first capture happens on the first clk edge after release.

Optional Feature:
- Macro: SERIALIZER_CHECKSUM_EN.
- Defined:
  - Adds state CSUM after DATA.
  - The checksum word is the XOR of the frame-count word and all WORDS data words, computed from the captured register.
  - m_last moves from the last data beat to the CSUM beat.
  - The back-to-back capture window moves to the CSUM beat.
  - Frame length becomes WORDS+3 beats.
- Undefined: no CSUM state; behaviour exactly as above.

Test Plan:
- Single frame, m_ready=1, in_data words 0..7 = 8'h10..8'h17 -> m_valid from cycle t+1; stream A5,00,10,11,...,17 on 10 consecutive cycles; m_last only on 17; busy falls after it.
- Backpressure: m_ready toggles 1,0,0,1 repeating -> same 10-word sequence; m_data/m_last stable during every stall; no duplicated or lost words.
- Overflow: second in_valid while streaming word 3 -> word sequence unchanged; overflow=1 and stays 1; next accepted frame carries count 01.
- Back-to-back: in_valid coincident with the final beat, m_ready=1 -> SYNC A5 on the very next cycle; count word increments; overflow stays 0.
- Counter wrap: 257 frames sent -> count words 00..FF then 00.
- Reset mid-frame: arest_n low during DATA index 4 -> m_valid=0 asynchronously. After release, the next frame starts with A5,00. With SERIALIZER_CHECKSUM_EN: frame 10..17, count 00 -> CSUM beat 8'h00, and m_last is on the CSUM beat.
